mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports A and B, inputs, SIZE bits each: the EX-stage operands shared with the ALU (A is the multiplicand or dividend; B is the multiplier or divisor).
REQ-005 The block SHALL have port op, input, 2 bits, decoded as: 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
REQ-006 The block SHALL have port start, input, 1 bit: a request, sampled on a rising edge while the block is not busy.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse indicating that hi and lo have just been updated.
REQ-009 The block SHALL have ports hi and lo, outputs, SIZE bits each: for a multiply, the upper and lower product halves; for a divide, the remainder and the quotient respectively.
REQ-010 The block SHALL have port divZero, output, 1 bit: set when the last divide had B == 0.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-012 Transitions SHALL be:
  - IDLE -> CALC on start.
  - CALC -> FIX after SIZE iterations.
  - FIX -> DONE.
  - DONE -> CALC if start is high, otherwise DONE -> IDLE.
REQ-013 busy SHALL be high in CALC and FIX and low in IDLE and DONE.
REQ-014 done SHALL be high only in DONE.
REQ-015 On acceptance, the block SHALL latch op and convert A and B to magnitudes (signed ops only); later changes to A, B or op SHALL have no effect on the operation in flight.
REQ-016 start asserted while busy is high SHALL be ignored, with no queuing.
REQ-017 Multiply SHALL use iterative shift-add, one multiplier bit per CALC cycle, with a 2*SIZE-bit accumulator.
REQ-018 Divide SHALL use restoring division, one quotient bit per CALC cycle, with a SIZE-bit iteration counter.
REQ-019 FIX SHALL apply sign correction as follows:
  - Signed product: negated when sign(A) != sign(B).
  - Signed quotient: negated when the signs differ; it truncates toward zero.
  - Remainder: takes the sign of A.
REQ-020 hi and lo SHALL be written only on the FIX -> DONE edge, and SHALL hold their values until the next completion.
REQ-021 Latency: done SHALL be high exactly SIZE+2 rising edges after the edge that accepted start; back-to-back starts accepted in DONE give a throughput of one result per SIZE+2 cycles.
REQ-022 Division by zero (DIV or DIVU with B == 0), regardless of signedness:
  - hi = A (original, uncorrected).
  - lo = all ones.
  - divZero = 1.
REQ-023 divZero SHALL be cleared on the acceptance of any new start.
REQ-024 DIV of the most negative value by -1 SHALL give lo = the most negative value and hi = 0, with no flag.
REQ-025 Multiplies SHALL never set divZero.
REQ-026 The block SHALL generate no X or Z on any output in any state.

Reset
REQ-027 While rst is high, the state SHALL be IDLE and busy, done, divZero, hi, lo and all internal registers SHALL be 0, regardless of clk.
REQ-028 rst asserted mid-operation SHALL abort it, with no done pulse and no hi/lo update.
REQ-029 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification (SIZE = 32)
REQ-030 MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF, start pulse -> busy next cycle; done on edge 34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT, A=0xFFFFFFFD (-3), B=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; divZero=0.
REQ-032 DIV, A=0xFFFFFFF9 (-7), B=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-033 DIVU, A=0x0000000A, B=0 -> hi=0x0000000A, lo=0xFFFFFFFF, divZero=1. A following MULTU start -> divZero=0 on the accept edge.
REQ-034 Start DIVU, 100/7; change A, B, op and pulse start at edge 5; assert rst at edge 10 -> result unaffected by the edge-5 changes (not observable); at reset busy=0, done never pulses, hi=lo=0. Restart 100/7 -> lo=14, hi=2 at edge 34.
REQ-035 Hold start high continuously with alternating ops -> a done pulse every 34 cycles, with each result matching a software reference model over 10k random signed and unsigned operand pairs, including 0, 1, all-ones and the most negative value.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed/unsigned multiply and divide unit
// Shift-add multiply and restoring divide on magnitudes; signs are restored in FIX.
module mult_div_unit #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic [1:0]      op,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] hi,
  output logic [SIZE-1:0] lo,
  output logic            divZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t r_state, w_next;

  logic [2*SIZE-1:0] r_acc;
  logic [SIZE-1:0]   r_opnd;
  logic [SIZE-1:0]   r_a_orig;
  logic              r_b_sign;
  logic [1:0]        r_op;
  logic [SIZE-1:0]   r_cnt;
  logic [SIZE-1:0]   r_hi;
  logic [SIZE-1:0]   r_lo;
  logic              r_div_zero;

  logic              w_accept;
  logic              w_last;
  logic [SIZE-1:0]   w_a_mag;
  logic [SIZE-1:0]   w_b_mag;
  logic [SIZE:0]     w_sum;
  logic [SIZE:0]     w_shift;
  logic [SIZE-1:0]   w_diff;
  logic              w_ge;
  logic [2*SIZE-1:0] w_step;
  logic              w_signed;
  logic              w_neg_res;
  logic              w_neg_rem;
  logic              w_b_zero;
  logic [2*SIZE-1:0] w_prod;
  logic [SIZE-1:0]   w_hi;
  logic [SIZE-1:0]   w_lo;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == SIZE'(SIZE - 1));
  assign w_a_mag  = (!op[0] && A[SIZE-1]) ? -A : A;
  assign w_b_mag  = (!op[0] && B[SIZE-1]) ? -B : B;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_sum   = {1'b0, r_acc[2*SIZE-1:SIZE]} + (r_acc[0] ? {1'b0, r_opnd} : {(SIZE+1){1'b0}});
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifted left each step.
  assign w_shift = r_acc[2*SIZE-1:SIZE-1];
  assign w_ge    = (w_shift >= {1'b0, r_opnd});
  assign w_diff  = w_shift[SIZE-1:0] - r_opnd;
  assign w_step  = r_op[1] ? {(w_ge ? w_diff : w_shift[SIZE-1:0]), r_acc[SIZE-2:0], w_ge}
                           : {w_sum, r_acc[SIZE-1:1]};

  assign w_signed  = !r_op[0];
  assign w_neg_res = w_signed && (r_a_orig[SIZE-1] ^ r_b_sign);
  assign w_neg_rem = w_signed && r_a_orig[SIZE-1];
  assign w_b_zero  = (r_opnd == '0);
  assign w_prod    = w_neg_res ? -r_acc : r_acc;

  always_comb begin
    w_hi = w_prod[2*SIZE-1:SIZE];
    w_lo = w_prod[SIZE-1:0];
    if (r_op[1]) begin
      if (w_b_zero) begin
        w_hi = r_a_orig;
        w_lo = '1;
      end else begin
        w_hi = w_neg_rem ? -r_acc[2*SIZE-1:SIZE] : r_acc[2*SIZE-1:SIZE];
        w_lo = w_neg_res ? -r_acc[SIZE-1:0] : r_acc[SIZE-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = start ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_opnd     <= '0;
      r_a_orig   <= '0;
      r_b_sign   <= 1'b0;
      r_op       <= 2'b00;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_acc      <= {{SIZE{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
      r_opnd     <= op[1] ? w_b_mag : w_a_mag;
      r_a_orig   <= A;
      r_b_sign   <= B[SIZE-1];
      r_op       <= op;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
    end else if (r_state == CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + SIZE'(1);
    end else if (r_state == FIX) begin
      r_hi       <= w_hi;
      r_lo       <= w_lo;
      r_div_zero <= r_op[1] && w_b_zero;
    end
  end

  assign busy    = (r_state == CALC) || (r_state == FIX);
  assign done    = (r_state == DONE);
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign divZero = r_div_zero;

endmodule
